// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: bundles the serial line and the received-byte outputs of
// the UART receive front-end.
//   rx        - raw serial line, idle high (driven by the line side)
//   po_data   - last correctly received byte
//   po_flag   - one-cycle strobe, po_data updated this cycle
//   frame_err - one-cycle strobe, stop bit sampled low and byte discarded
//   rx_busy   - high while a frame is being received
// Modports:
//   master - the receiver: consumes rx, produces the byte outputs
//   slave  - the line/consumer side: drives rx, observes the byte outputs
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx,
    output po_data,
    output po_flag,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx,
    input  po_data,
    input  po_flag,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver, LSB first. Recovers bytes from the raw
// asynchronous rx line and presents each one as a single-cycle po_flag strobe
// with po_data. Start-bit glitches are dropped silently; a low stop bit gives
// a single-cycle frame_err strobe and the byte is discarded.
// Ports:
//   sys_clk   - system clock, all logic on the rising edge
//   sys_rst_n - asynchronous active-low reset
//   bus       - uart_rx_byte_if.master (rx in; po_data, po_flag, frame_err,
//               rx_busy out)
// Parameters:
//   CLK_FREQ  - system clock frequency in Hz
//   UART_BPS  - line baud rate; CLK_FREQ/UART_BPS must be at least 4
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_rx_byte_if.master bus
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int MID          = BAUD_CNT_MAX / 2;
  localparam int CW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);

  // With fewer than 4 clocks per bit the sample point and the wrap point
  // could coincide, which the state machine below does not handle.
  if (BAUD_CNT_MAX < 4) begin : g_bad_baud
    $error("uart_rx_byte: CLK_FREQ/UART_BPS must be >= 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          sync1, sync2, rx_d;
  logic [7:0]    po_data;
  logic          po_flag, frame_err, rx_busy;

  logic fall, sample, wrap;

  // Synchronizer flops reset high so that releasing reset with an idle line
  // cannot look like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      sync2 <= sync1;
      rx_d  <= sync2;
    end
  end

  assign fall   = !sync2 && rx_d;
  assign sample = (cnt == CNT_MID);
  assign wrap   = (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || wrap) cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (sample) begin
            if (sync2) begin
              // Line already back high mid start bit: treat as noise.
              state   <= IDLE;
              rx_busy <= 1'b0;
              cnt     <= '0;
            end else begin
              bit_cnt <= '0;
            end
          end else if (wrap) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (sample) begin
            shift   <= {sync2, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (wrap && bit_cnt == 4'd8) begin
            state <= STOP;
          end
        end

        STOP: begin
          // Leave at the stop sample rather than the end of the stop bit so
          // that a start bit immediately following is not missed.
          if (sample) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            cnt     <= '0;
            if (sync2) begin
              po_data <= shift;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.po_data   = po_data;
  assign bus.po_flag   = po_flag;
  assign bus.frame_err = frame_err;
  assign bus.rx_busy   = rx_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

  localparam int B   = 5;     // clocks per bit, fast instance
  localparam int MID = 2;
  localparam int BS  = 5208;  // clocks per bit, default instance
  localparam int SLOW_LAT = 9 * 5208 + 2604 + 1;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #10 sys_clk = ~sys_clk;

  uart_rx_byte_if bus1 ();
  uart_rx_byte_if bus2 ();

  uart_rx_byte #(.CLK_FREQ(50_000_000), .UART_BPS(10_000_000)) u_fast (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1)
  );

  uart_rx_byte u_slow (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor, sampling on the falling edge
  int         cyc = 0;
  logic [7:0] data1_q[$];
  int         t1_q[$];
  int         ferr1 = 0;
  int         both1 = 0;
  int         busy1 = 0;
  int         start2 = 0;
  int         flag2_t = 0;
  int         flag2_n = 0;
  int         ferr2 = 0;
  logic [7:0] data2 = 8'h00;
  logic       busy2_d = 1'b0;

  always @(negedge sys_clk) begin
    cyc++;
    if (bus1.po_flag) begin
      data1_q.push_back(bus1.po_data);
      t1_q.push_back(cyc);
      $display("[%0d] fast rx byte 0x%02h", cyc, bus1.po_data);
    end
    if (bus1.frame_err) begin
      ferr1++;
      $display("[%0d] fast frame_err", cyc);
    end
    if (bus1.po_flag && bus1.frame_err) both1++;
    if (bus1.rx_busy) busy1++;
    if (bus2.rx_busy && !busy2_d) start2 = cyc;
    busy2_d = bus2.rx_busy;
    if (bus2.po_flag) begin
      flag2_n++;
      flag2_t = cyc;
      data2 = bus2.po_data;
      $display("[%0d] slow rx byte 0x%02h", cyc, bus2.po_data);
    end
    if (bus2.frame_err) ferr2++;
  end

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 1) bus1.rx = v;
    else          bus2.rx = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_v, input int n);
    drive(sel, 1'b0, n);
    for (int i = 0; i < 8; i++) drive(sel, b[i], n);
    drive(sel, stop_v, n);
  endtask

  int base, fbase, bbase;

  initial begin
    bus1.rx = 1'b1;
    bus2.rx = 1'b1;
    sys_rst_n = 1'b0;
    #5;
    check("rst_po_data", {24'd0, bus1.po_data}, 32'h00);
    check("rst_po_flag", {31'd0, bus1.po_flag}, 32'd0);
    check("rst_frame_err", {31'd0, bus1.frame_err}, 32'd0);
    check("rst_rx_busy", {31'd0, bus1.rx_busy}, 32'd0);
    #15;
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // 1: stream 0x00..0x0F back to back
    base = data1_q.size();
    fbase = ferr1;
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 1'b1, B);
    repeat (10) @(negedge sys_clk);
    check("stream_count", 32'(data1_q.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      if (base + i < data1_q.size())
        check($sformatf("stream_byte%0d", i), {24'd0, data1_q[base + i]}, 32'(i));
    check("stream_no_ferr", 32'(ferr1 - fbase), 32'd0);

    // 2: glitch of two clocks
    base = data1_q.size();
    fbase = ferr1;
    bbase = busy1;
    drive(1, 1'b0, 2);
    drive(1, 1'b1, 12);
    check("glitch_no_flag", 32'(data1_q.size() - base), 32'd0);
    check("glitch_no_ferr", 32'(ferr1 - fbase), 32'd0);
    check("glitch_busy_len_ok", {31'd0, (busy1 - bbase) >= 1 && (busy1 - bbase) <= MID + 1}, 32'd1);
    check("glitch_busy_low", {31'd0, bus1.rx_busy}, 32'd0);
    send_byte(1, 8'h5A, 1'b1, B);
    repeat (10) @(negedge sys_clk);
    check("after_glitch_count", 32'(data1_q.size() - base), 32'd1);
    check("after_glitch_data", {24'd0, bus1.po_data}, 32'h5A);

    // 3: framing error
    base = data1_q.size();
    fbase = ferr1;
    send_byte(1, 8'h3C, 1'b0, B);
    drive(1, 1'b1, 2 * B);
    check("ferr_count", 32'(ferr1 - fbase), 32'd1);
    check("ferr_no_flag", 32'(data1_q.size() - base), 32'd0);
    check("ferr_data_held", {24'd0, bus1.po_data}, 32'h5A);
    send_byte(1, 8'hC3, 1'b1, B);
    repeat (10) @(negedge sys_clk);
    check("after_ferr_count", 32'(data1_q.size() - base), 32'd1);
    check("after_ferr_data", {24'd0, bus1.po_data}, 32'hC3);
    check("after_ferr_no_new_ferr", 32'(ferr1 - fbase), 32'd1);

    // 4: reset during bit 4 of 0xFF
    base = data1_q.size();
    drive(1, 1'b0, B);
    for (int i = 0; i < 4; i++) drive(1, 1'b1, B);
    drive(1, 1'b1, 2);
    check("midrst_busy_before", {31'd0, bus1.rx_busy}, 32'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_po_data", {24'd0, bus1.po_data}, 32'h00);
    check("midrst_rx_busy", {31'd0, bus1.rx_busy}, 32'd0);
    check("midrst_po_flag", {31'd0, bus1.po_flag}, 32'd0);
    @(negedge sys_clk);
    drive(1, 1'b1, 3);
    sys_rst_n = 1'b1;
    drive(1, 1'b1, 4 * B + 10);
    check("midrst_no_strobe", 32'(data1_q.size() - base), 32'd0);
    send_byte(1, 8'h81, 1'b1, B);
    repeat (10) @(negedge sys_clk);
    check("midrst_after_count", 32'(data1_q.size() - base), 32'd1);
    check("midrst_after_data", {24'd0, bus1.po_data}, 32'h81);

    // 6: minimum gap frames
    base = data1_q.size();
    send_byte(1, 8'hFF, 1'b1, B);
    send_byte(1, 8'h00, 1'b1, B);
    repeat (10) @(negedge sys_clk);
    check("gap_count", 32'(data1_q.size() - base), 32'd2);
    if (data1_q.size() - base == 2) begin
      check("gap_byte0", {24'd0, data1_q[base]}, 32'hFF);
      check("gap_byte1", {24'd0, data1_q[base + 1]}, 32'h00);
      check("gap_spacing", 32'(t1_q[base + 1] - t1_q[base]), 32'(10 * B));
    end
    check("never_flag_and_ferr", 32'(both1), 32'd0);

    // 5: default parameters, 0xA5
    send_byte(2, 8'hA5, 1'b1, BS);
    repeat (20) @(negedge sys_clk);
    check("slow_count", 32'(flag2_n), 32'd1);
    check("slow_data", {24'd0, data2}, 32'hA5);
    check("slow_latency", 32'(flag2_t - start2), 32'(SLOW_LAT));
    check("slow_no_ferr", 32'(ferr2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
